// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage load/store engine and the memory.
// Latency: none, wires only.
// Backpressure: the master holds request fields until the slave raises dmem_gnt.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [31:0]           dmem_wdata;
  logic [3:0]            dmem_be;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [31:0]           dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: byte-lane formatting, request/grant/response bus, timeout.
// Latency: store done 2 cycles after accept, load 3 (earliest bus responses); faults in 1.
// Backpressure: stall is held while an access is outstanding; the bus holds the request until grant.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           load_result,
  output logic                  access_fault,
  output logic [1:0]            fault_cause,
  mem_access_unit_if.master     dmem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  logic [1:0]            state;
  logic [1:0]            size_q;      // 0 byte, 1 half, 2 word
  logic                  unsigned_q;  // funct3[2]: zero-extend loads
  logic [1:0]            off_q;       // byte offset inside the word
  logic                  resp_fault_q;
  logic [7:0]            wait_cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;

  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic [3:0]            be_c;
  logic [31:0]           wdata_c;
  logic [31:0]           lane;
  logic [31:0]           load_ext;
  logic [8:0]            cnt_next;
  logic                  timeout;

  assign accept = ex_valid & (mem_read | mem_write);

  // Decode legality and alignment of the incoming access.
  always_comb begin
    illegal = (mem_read & mem_write)
            | (mem_write & (funct3[2] | (funct3[1:0] == 2'b11)))
            | (mem_read & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)));
    misaligned = ((funct3[1:0] == 2'b01) & addr[0])
               | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  // Byte-lane strobes and replicated store data for the incoming access.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << addr[1:0];
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  // Shift the addressed lane down and sign/zero extend it.
  always_comb begin
    lane     = dmem.dmem_rdata >> {off_q, 3'b000};
    load_ext = lane;
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'd1:    load_ext = unsigned_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Timeout fires on the cycle the REQ+WAIT cycle count reaches MAX_WAIT.
  always_comb begin
    cnt_next = {1'b0, wait_cnt} + 9'd1;
    timeout  = (cnt_next >= 9'(MAX_WAIT));
  end

  // Handshake outputs derived from the current state.
  always_comb begin
    stall        = 1'b0;
    case (state)
      S_IDLE:  stall = accept;
      S_REQ:   stall = 1'b1;
      S_WAIT:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
    done         = (state == S_RESP) & ~resp_fault_q;
    access_fault = (state == S_RESP) & resp_fault_q;
  end

  assign dmem.dmem_req   = (state == S_REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  // Access sequencer: accept, request until grant, wait for read data, report.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      off_q        <= 2'd0;
      resp_fault_q <= 1'b0;
      wait_cnt     <= 8'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      load_result  <= 32'd0;
      fault_cause  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            size_q     <= funct3[1:0];
            unsigned_q <= funct3[2];
            off_q      <= addr[1:0];
            if (illegal) begin
              resp_fault_q <= 1'b1;
              fault_cause  <= CAUSE_ILLEGAL;
              state        <= S_RESP;
            end else if (misaligned) begin
              resp_fault_q <= 1'b1;
              fault_cause  <= CAUSE_MISALIGN;
              state        <= S_RESP;
            end else begin
              resp_fault_q <= 1'b0;
              we_q         <= mem_write;
              addr_q       <= {addr[ADDR_WIDTH-1:2], 2'b00};
              wdata_q      <= mem_write ? wdata_c : 32'd0;
              be_q         <= be_c;
              state        <= S_REQ;
            end
          end
        end
        S_REQ: begin
          wait_cnt <= cnt_next[7:0];
          if (dmem.dmem_gnt && we_q) begin
            state <= S_RESP;
          end else if (timeout) begin
            resp_fault_q <= 1'b1;
            fault_cause  <= CAUSE_TIMEOUT;
            state        <= S_RESP;
          end else if (dmem.dmem_gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= cnt_next[7:0];
          if (dmem.dmem_rvalid) begin
            load_result <= load_ext;
            state       <= S_RESP;
          end else if (timeout) begin
            resp_fault_q <= 1'b1;
            fault_cause  <= CAUSE_TIMEOUT;
            state        <= S_RESP;
          end
        end
        default: begin
          wait_cnt <= 8'd0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine, downstream of the control unit.
- Consumes the decoded memory controls (read/write enable, funct3 size/sign) plus the EX-stage address and store data.
- Drives a request/grant/response data-memory bus: byte-lane strobes and replicated write data on stores; lane extraction with sign/zero extension on loads.
- Stalls the pipeline while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- MAX_WAIT, 16, max cycles in REQ+WAIT before a timeout fault; range 2..255.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  instruction in MEM stage is valid.
- mem_read  in  1  load instruction.
- mem_write  in  1  store instruction.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_WIDTH  byte address from ALU.
- store_data  in  32  rs2 value.
- stall  out  1  hold pipeline.
- done  out  1  one-cycle pulse, access completed.
- load_result  out  32  extended load data.
- access_fault  out  1  one-cycle pulse, access aborted.
- fault_cause  out  2  01 misaligned, 10 illegal, 11 timeout.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write request.
- dmem_addr  out  ADDR_WIDTH  word-aligned address, addr[1:0]=00.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.

Behaviour:

Reset:
- Next edge → state IDLE.
- stall=0, done=0, access_fault=0, fault_cause=00, load_result=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, wait counter=0.
- Reset in any state aborts the access; no done/fault is reported for it.

FSM states: IDLE, REQ, WAIT, RESP.

IDLE:
- accept = ex_valid & (mem_read | mem_write).
- stall = accept, combinational in the same cycle.
- On accept, register address/data/size, then:
  - Both mem_read and mem_write high, or funct3 ∉ {000,001,010,100,101} (stores: ∉ {000,001,010}) → RESP, fault cause 10.
  - Misaligned → RESP, fault cause 01. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - Otherwise → REQ.
- Faults never raise dmem_req.

Store lane formatting:
- SB: wdata={4{d[7:0]}}, be=0001<<addr[1:0].
- SH: wdata={2{d[15:0]}}, be=0011<<addr[1:0].
- SW: wdata=d, be=1111.

Load lane formatting:
- be uses the same masks; wdata=0; we=0.

REQ:
- dmem_req=1. Address, we, be and wdata are held stable until dmem_gnt is sampled high.
- Grant on a store → RESP (write complete at grant).
- Grant on a load → WAIT.
- dmem_rvalid in REQ is ignored.
- dmem_req drops in the cycle after grant.

WAIT:
- On dmem_rvalid: lane = rdata >> (8*addr[1:0]).
- B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- Result is registered into load_result → RESP.

Timeout:
- Counter increments each cycle in REQ or WAIT.
- If it reaches MAX_WAIT without completion → RESP, cause 11; dmem_req deasserted.

RESP:
- stall=0.
- Success → done=1; fault → access_fault=1, fault_cause updated. done and access_fault are mutually exclusive.
- Counter cleared.
- Returns to IDLE unconditionally. It never accepts; ex_valid here still belongs to the completing instruction.

Hold behaviour:
- load_result changes only on load completion.
- fault_cause holds until the next fault.
- Stores do not change load_result.

Stray responses:
- dmem_rvalid/dmem_gnt while in IDLE or RESP are ignored, e.g. late responses after timeout or reset.

Latency (bus responses on the earliest cycle):
- Store: accept cycle 0, grant cycle 1, done cycle 2.
- Load: grant cycle 1, rvalid cycle 2, done cycle 3.
- Stall is high on cycles 0..N-1 and low on the done/fault cycle.

Test Plan:
1. SB addr=0x1003, store_data=0x000000A5, gnt in cycle 1 → dmem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, we=1; done cycle 2; stall high cycles 0–1 only.
2. LH addr=0x2002, gnt cycle 1, rvalid cycle 3 with rdata=0x80017FFF → load_result=0xFFFF8001, done cycle 4. The same access as LHU → 0x00008001.
3. LW addr=0x2001 → dmem_req never asserted; access_fault=1, fault_cause=01 in cycle 1; done=0; load_result unchanged. funct3=011 load → cause 10.
4. Load with dmem_gnt held 0, MAX_WAIT=16 → dmem_req high 16 cycles then drops; access_fault, cause 11 next cycle; later stray rvalid does not change load_result.
5. rst pulsed while in WAIT → next edge all outputs at reset values, state IDLE; rvalid the following cycle ignored; a new LW afterwards completes normally.
6. ex_valid=1 with mem_read=mem_write=0 for 5 cycles → stall=0, dmem_req=0, no done/fault. Then back-to-back SW 0x3000 / LBU 0x3001 → two distinct done pulses, each access issued only after the prior RESP.
